store_size_unit: RTL and testbench

Sequential store-size stage for the multicycle datapath, placed directly upstream of the memory write-data multiplexer. It produces the `store_size_data` word that the multiplexer selects for SB and SH. For sub-word stores it reads the aligned memory word, waits out the memory latency, merges the low byte or halfword of register B into the correct lane, and then presents the merged word with a write strobe. It also flags misaligned or reserved store requests back to the control unit.

---
 rtl/store_size_unit_pkg.sv | 31 +++
 rtl/store_size_unit_merge.sv | 38 +++
 rtl/store_size_unit.sv | 128 ++++++++++++
 tb/tb_store_size_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/store_size_unit_pkg.sv
// store_size_pkg: shared definitions for the store-size stage.
//   - store-type encodings (SW / SH / SB; 2'b11 is reserved)
//   - FSM state encoding, also exposed on the top-level debug port
//   - is_store_err(): classifies a request as misaligned or reserved
package store_size_pkg;

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_ERR   = 2'b11
  } state_t;

  // A word store must be word aligned and a halfword store halfword aligned.
  // A byte store is always legal. The reserved type is always rejected.
  function automatic logic is_store_err(input logic [1:0] st, input logic [1:0] a);
    logic err;
    case (st)
      ST_WORD: err = (a != 2'b00);
      ST_HALF: err = a[0];
      ST_BYTE: err = 1'b0;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/store_size_unit_merge.sv
// store_merge: combinational lane merge for sub-word stores (little-endian).
// Ports:
//   type_i     [1:0]  store type (ST_WORD / ST_HALF / ST_BYTE)
//   addr_low_i [1:0]  byte offset within the aligned word
//   b_i        [31:0] register B contents
//   mem_word_i [31:0] aligned memory word read back
//   merged_o   [31:0] memory word with B's low byte/halfword placed in its lane
module store_merge
  import store_size_pkg::*;
(
  input  logic [1:0]  type_i,
  input  logic [1:0]  addr_low_i,
  input  logic [31:0] b_i,
  input  logic [31:0] mem_word_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = mem_word_i;
    case (type_i)
      ST_BYTE: begin
        case (addr_low_i)
          2'd0:    merged_o[7:0]   = b_i[7:0];
          2'd1:    merged_o[15:8]  = b_i[7:0];
          2'd2:    merged_o[23:16] = b_i[7:0];
          default: merged_o[31:24] = b_i[7:0];
        endcase
      end
      ST_HALF: begin
        // Only offsets 0 and 2 reach here; bit 0 is screened out as an error.
        if (addr_low_i[1]) merged_o[31:16] = b_i[15:0];
        else               merged_o[15:0]  = b_i[15:0];
      end
      default: merged_o = b_i;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// store_size_unit: sequential store-size stage ahead of the memory write-data mux.
// SW passes register B straight through; SB/SH read the aligned word, wait
// MEM_LATENCY cycles, merge B into the addressed lane and then write.
// Ports:
//   clk, reset             clock; synchronous active-low reset
//   start                  request pulse, sampled only in IDLE
//   store_type, addr_low   request type and byte offset
//   reg_B_data             B register contents
//   mem_read_data          aligned memory word (valid in the final READ cycle)
//   mem_read_req           memory read request (READ state)
//   mem_write_en, done     one-cycle write strobe / completion pulse (WRITE state)
//   store_size_data        registered merged word
//   busy                   any state other than IDLE
//   misalign_err           one-cycle pulse on a rejected request (ERR state)
//   dbg_state_o            current FSM state
//
// Handshake: start is a single-cycle request that is accepted only while busy
// is low; a request seen while busy is dropped, not queued. Each accepted
// request ends with exactly one one-cycle pulse, either done (together with
// mem_write_en) or misalign_err, and the block is idle again the next cycle.
module store_size_unit
  import store_size_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] reg_B_data,
  input  logic [31:0] mem_read_data,
  output logic        mem_read_req,
  output logic        mem_write_en,
  output logic [31:0] store_size_data,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output state_t      dbg_state_o
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    type_q, type_d;
  logic [1:0]    addr_q, addr_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   merged;

  // Merge always works from the latched request, so inputs may change
  // freely once start has been accepted.
  store_merge u_merge (
    .type_i     (type_q),
    .addr_low_i (addr_q),
    .b_i        (b_q),
    .mem_word_i (mem_read_data),
    .merged_o   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= 2'b00;
      addr_q  <= 2'b00;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    addr_d  = addr_q;
    b_d     = b_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          type_d = store_type;
          addr_d = addr_low;
          b_d    = reg_B_data;
          if (is_store_err(store_type, addr_low)) begin
            state_d = S_ERR;
          end else if (store_type == ST_WORD) begin
            // SW needs no read: B is the write data as-is.
            data_d  = reg_B_data;
            state_d = S_WRITE;
          end else begin
            cnt_d   = CW'(1);
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (cnt_q == CNT_LAST) begin
          data_d  = merged;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_read_req    = (state_q == S_READ);
  assign mem_write_en    = (state_q == S_WRITE);
  assign done            = (state_q == S_WRITE);
  assign misalign_err    = (state_q == S_ERR);
  assign busy            = (state_q != S_IDLE);
  assign store_size_data = data_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_store_size_unit.sv
// Bench for store_size_unit: two instances (latency 1 and latency 3) share one
// stimulus stream. The driver pushes the expected event (write or error, data,
// cycle) into a per-instance queue; monitors pop and compare on each event.
module tb_store_size_unit;
  import store_size_pkg::*;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  store_type = 2'b00;
  logic [1:0]  addr_low = 2'b00;
  logic [31:0] reg_B_data = '0;
  logic [31:0] mem_read_data = '0;

  logic        rr1, we1, busy1, done1, me1;
  logic [31:0] d1;
  state_t      st1;
  logic        rr3, we3, busy3, done3, me3;
  logic [31:0] d3;
  state_t      st3;

  exp_t exp1_q[$];
  exp_t exp3_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd1 = 0, rd3 = 0, wr1 = 0, wr3 = 0;
  logic [31:0] last_data = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  store_size_unit #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type),
    .addr_low(addr_low), .reg_B_data(reg_B_data), .mem_read_data(mem_read_data),
    .mem_read_req(rr1), .mem_write_en(we1), .store_size_data(d1), .busy(busy1),
    .done(done1), .misalign_err(me1), .dbg_state_o(st1)
  );

  store_size_unit #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .store_type(store_type),
    .addr_low(addr_low), .reg_B_data(reg_B_data), .mem_read_data(mem_read_data),
    .mem_read_req(rr3), .mem_write_en(we3), .store_size_data(d3), .busy(busy3),
    .done(done3), .misalign_err(me3), .dbg_state_o(st3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rr1) rd1++;
    if (we1) wr1++;
    if (we1 || me1) begin
      if (exp1_q.size() == 0) begin
        check("l1_unexpected_event", {30'd0, we1, me1}, 32'd0);
      end else begin
        e = exp1_q.pop_front();
        check("l1_event_kind", {31'd0, me1}, {31'd0, e.is_err});
        check("l1_event_data", d1, e.data);
        check("l1_event_cycle", cyc, e.cyc);
        check("l1_done_with_wr", {31'd0, done1}, {31'd0, we1});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rr3) rd3++;
    if (we3) wr3++;
    if (we3 || me3) begin
      if (exp3_q.size() == 0) begin
        check("l3_unexpected_event", {30'd0, we3, me3}, 32'd0);
      end else begin
        e = exp3_q.pop_front();
        check("l3_event_kind", {31'd0, me3}, {31'd0, e.is_err});
        check("l3_event_data", d3, e.data);
        check("l3_event_cycle", cyc, e.cyc);
        check("l3_done_with_wr", {31'd0, done3}, {31'd0, we3});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy1 && !busy3 && exp1_q.size() == 0 && exp3_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check({name, "_completes"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] t, input logic [1:0] a,
                       input logic [31:0] b, input logic [31:0] m, output int t0);
    @(posedge clk); #1;
    t0 = cyc;
    store_type = t; addr_low = a; reg_B_data = b; mem_read_data = m;
    start = 1'b1;
    rd1 = 0; rd3 = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One complete request: is_err selects an ERR outcome; SW completes at t+1,
  // SB/SH at t+L+1; errors report the unchanged data register.
  task automatic run_op(input string name, input logic [1:0] t, input logic [1:0] a,
                        input logic [31:0] b, input logic [31:0] m,
                        input logic is_err, input logic [31:0] exp_data);
    int t0;
    bit sub;
    int w1, w3;
    logic [31:0] ed;
    sub = !is_err && (t != ST_WORD);
    ed  = is_err ? last_data : exp_data;
    w1 = wr1; w3 = wr3;
    @(posedge clk); #1;
    t0 = cyc + 1;
    exp1_q.push_back('{is_err, ed, 32'(t0 + (sub ? 2 : 1))});
    exp3_q.push_back('{is_err, ed, 32'(t0 + (sub ? 4 : 1))});
    issue(t, a, b, m, t0);
    wait_idle(name);
    check({name, "_l1_reads"}, rd1, sub ? 32'd1 : 32'd0);
    check({name, "_l3_reads"}, rd3, sub ? 32'd3 : 32'd0);
    check({name, "_l1_writes"}, wr1 - w1, is_err ? 32'd0 : 32'd1);
    check({name, "_l3_writes"}, wr3 - w3, is_err ? 32'd0 : 32'd1);
    last_data = ed;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_l1_outs"}, {26'd0, rr1, we1, busy1, done1, me1, 1'b0}, 32'd0);
    check({name, "_l3_outs"}, {26'd0, rr3, we3, busy3, done3, me3, 1'b0}, 32'd0);
    check({name, "_l1_data"}, d1, 32'd0);
    check({name, "_l3_data"}, d3, 32'd0);
    check({name, "_l1_state"}, {30'd0, st1}, {30'd0, S_IDLE});
    check({name, "_l3_state"}, {30'd0, st3}, {30'd0, S_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, w1, w3;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("sw_a00",     ST_WORD, 2'b00, 32'h12345678, 32'h0,         1'b0, 32'h12345678);
    run_op("sb_a01",     ST_BYTE, 2'b01, 32'h12345678, 32'hAABBCCDD,  1'b0, 32'hAABB78DD);
    run_op("sh_a10",     ST_HALF, 2'b10, 32'h12345678, 32'hAABBCCDD,  1'b0, 32'h5678CCDD);
    run_op("sb_a00",     ST_BYTE, 2'b00, 32'h12345678, 32'hAABBCCDD,  1'b0, 32'hAABBCC78);
    run_op("sb_a10",     ST_BYTE, 2'b10, 32'h12345678, 32'hAABBCCDD,  1'b0, 32'hAA78CCDD);
    run_op("sb_a11",     ST_BYTE, 2'b11, 32'h000000EE, 32'h11223344,  1'b0, 32'hEE223344);
    run_op("sh_a00",     ST_HALF, 2'b00, 32'hCAFEBEEF, 32'h11223344,  1'b0, 32'h1122BEEF);
    run_op("err_sh_a11", ST_HALF, 2'b11, 32'hFFFFFFFF, 32'h0,         1'b1, 32'h0);
    run_op("err_rsvd",   2'b11,   2'b00, 32'hFFFFFFFF, 32'h0,         1'b1, 32'h0);
    run_op("err_sw_a01", ST_WORD, 2'b01, 32'hFFFFFFFF, 32'h0,         1'b1, 32'h0);
    run_op("err_sh_a01", ST_HALF, 2'b01, 32'hFFFFFFFF, 32'h0,         1'b1, 32'h0);
    run_op("sw_b2b_1",   ST_WORD, 2'b00, 32'h0BADF00D, 32'h0,         1'b0, 32'h0BADF00D);
    run_op("sw_b2b_2",   ST_WORD, 2'b00, 32'hFEEDFACE, 32'h0,         1'b0, 32'hFEEDFACE);

    // start during READ is dropped: exactly one write, with the SB result
    w1 = wr1; w3 = wr3;
    @(posedge clk); #1;
    t0 = cyc + 1;
    exp1_q.push_back('{1'b0, 32'h11223355, 32'(t0 + 2)});
    exp3_q.push_back('{1'b0, 32'h11223355, 32'(t0 + 4)});
    issue(ST_BYTE, 2'b00, 32'h00000055, 32'h11223344, t0);
    store_type = ST_WORD; addr_low = 2'b00; reg_B_data = 32'hDEADBEEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    store_type = ST_BYTE; addr_low = 2'b00; reg_B_data = 32'h00000055;
    wait_idle("busy_start");
    repeat (3) @(negedge clk);
    check("busy_start_l1_writes", wr1 - w1, 32'd1);
    check("busy_start_l3_writes", wr3 - w3, 32'd1);
    last_data = 32'h11223355;

    // reset in the first READ cycle aborts the SB with no write
    w1 = wr1; w3 = wr3;
    issue(ST_BYTE, 2'b01, 32'h12345678, 32'hAABBCCDD, t0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (5) @(negedge clk);
    check("mid_reset_l1_no_write", wr1 - w1, 32'd0);
    check("mid_reset_l3_no_write", wr3 - w3, 32'd0);
    last_data = 32'h0;
    run_op("sw_after_rst", ST_WORD, 2'b00, 32'hA5A5C3C3, 32'h0, 1'b0, 32'hA5A5C3C3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
